// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment width, the
// hex-to-segment table ({g,f,e,d,c,b,a}, common cathode) and a clog2 helper.
package seg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-segment decoder driven from the shared table.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-aligned double
// buffering and leading-zero blanking. Define SEG_BRIGHTNESS_EN for PWM dimming.
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1024,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  localparam int unsigned IDX_W = (clog2(NUM_DIGITS) > 0) ? clog2(NUM_DIGITS) : 1,
  localparam int unsigned PS_W  = clog2(REFRESH_DIV),
  localparam int unsigned VAL_W = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  input  logic                  blank_lz,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start
);

  logic [PS_W-1:0]       prescaler;
  logic [VAL_W-1:0]      pending;
  logic [VAL_W-1:0]      display;
  logic                  tc;
  logic                  wrap;
  logic [3:0]            nib;
  logic [VAL_W-1:0]      upper;
  logic                  lz_blank;
  logic [SEG_W-1:0]      dec_seg;
  logic [SEG_W-1:0]      seg_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  always_comb begin
    tc   = enable && (prescaler == PS_W'(REFRESH_DIV - 1));
    wrap = tc && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  end

  // Blank when this nibble and every more-significant one are zero; digit 0 always shows.
  always_comb begin
    nib      = display[{digit_idx, 2'b00} +: 4];
    upper    = display >> {digit_idx, 2'b00};
    lz_blank = blank_lz && (digit_idx != '0) && (upper == '0);
  end

  seg_hex_decoder u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_nxt            = '0;
    sel_nxt            = '0;
    if (enable) begin
      seg_nxt            = lz_blank ? '0 : dec_seg;
      sel_nxt[digit_idx] = 1'b1;
`ifdef SEG_BRIGHTNESS_EN
      if (prescaler[PS_W-1 -: 4] >= brightness) sel_nxt = '0;
`endif
    end
  end

  // Pending is captured on load; display only takes it on the wrap edge, so a
  // load on that same edge lands one frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      digit_idx   <= '0;
      pending     <= '0;
      display     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (load) pending <= value;
      if (enable) prescaler <= prescaler + PS_W'(1);
      if (wrap) begin
        digit_idx <= '0;
        display   <= pending;
      end else if (tc) begin
        digit_idx <= digit_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg       <= SEG_ACTIVE_LOW ? '1 : '0;
      digit_sel <= SEG_ACTIVE_LOW ? '1 : '0;
    end else begin
      seg       <= SEG_ACTIVE_LOW ? ~seg_nxt : seg_nxt;
      digit_sel <= SEG_ACTIVE_LOW ? ~sel_nxt : sel_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: per-cycle model comparison
// plus directed literal checks of frames, blanking, pause and reset.
module tb_seven_segment_scanner;

`ifdef SEG_BRIGHTNESS_EN
  localparam int RD = 16;
`else
  localparam int RD = 4;
`endif
  localparam int N     = 4;
  localparam int FRAME = RD * N;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value    = '0;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd4;
`endif
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  // model state: enabled-cycle count since reset, display and pending words
  int          cnt    = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic [6:0]  e_seg;
  logic [3:0]  e_sel;
  logic [1:0]  e_idx;
  logic        e_fs;

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seven_segment_scanner #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .load        (load),
    .blank_lz    (blank_lz),
`ifdef SEG_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .seg         (seg),
    .digit_sel   (digit_sel),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot = (cnt / RD) % N; outputs after an edge describe the slot before it.
  initial begin
    int slot;
    logic [15:0] upper;
    forever begin
      @(posedge clk);
      if (reset) begin
        cnt = 0; m_disp = '0; m_pend = '0;
        e_seg = '0; e_sel = '0; e_idx = '0; e_fs = 1'b0;
      end else begin
        slot = (cnt / RD) % N;
        if (enable) begin
          upper = m_disp >> (4 * slot);
          e_sel = 4'(1 << slot);
`ifdef SEG_BRIGHTNESS_EN
          if (((cnt % RD) * 16 / RD) >= brightness) e_sel = '0;
`endif
          e_seg = (blank_lz && slot != 0 && upper == 16'h0) ? 7'h00 : hex_tab[upper[3:0]];
          e_fs  = ((cnt + 1) % FRAME) == 0;
          if (e_fs) m_disp = m_pend;
          cnt++;
        end else begin
          e_seg = '0; e_sel = '0; e_fs = 1'b0;
        end
        if (load) m_pend = value;
        e_idx = 2'((cnt / RD) % N);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      check("seg", 32'(seg), 32'(e_seg));
      check("digit_sel", 32'(digit_sel), 32'(e_sel));
      check("digit_idx", 32'(digit_idx), 32'(e_idx));
      check("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  // Waits (bounded) for frame_start, then checks every sample of the following frame.
  task automatic check_frame(input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] exp_d [4];
    int budget;
    exp_d  = '{d0, d1, d2, d3};
    budget = 4 * FRAME;
    while (frame_start !== 1'b1 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("frame_wait", 32'(frame_start), 32'd1);
    for (int k = 1; k <= FRAME; k++) begin
      @(posedge clk); #1;
      check("frame_seg", 32'(seg), 32'(exp_d[(k-1)/RD]));
`ifndef SEG_BRIGHTNESS_EN
      check("frame_sel", 32'(digit_sel), 32'(1 << ((k-1)/RD)));
`endif
      check("frame_fs", 32'(frame_start), 32'(k == FRAME));
    end
  endtask

  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge clk);
      if (cnt % FRAME == p) hit = 1'b1;
    end
    check("wait_pos", 32'(hit), 32'd1);
  endtask

  task automatic load_word(input logic [15:0] v);
    @(negedge clk);
    value = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    reset = 1'b0; enable = 1'b1; value = 16'h1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_frame(7'h66, 7'h4F, 7'h5B, 7'h06);

    // ABCD in slot 2, then 0000 on the wrap cycle
    wait_pos(2 * RD + 1);
    value = 16'hABCD; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("old_frame_seg", 32'(seg), 32'h5B);
    wait_pos(FRAME - 1);
    value = 16'h0000; load = 1'b1;
    fork
      begin @(negedge clk); load = 1'b0; end
    join_none
    check_frame(7'h5E, 7'h39, 7'h7C, 7'h77);
    check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);

    blank_lz = 1'b1;
    load_word(16'h0050);
    check_frame(7'h3F, 7'h6D, 7'h00, 7'h00);
    load_word(16'h0000);
    check_frame(7'h3F, 7'h00, 7'h00, 7'h00);

    blank_lz = 1'b0;
    load_word(16'h1234);
    check_frame(7'h66, 7'h4F, 7'h5B, 7'h06);

    // pause in slot 1 at offset 1
    wait_pos(RD + 1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_seg", 32'(seg), 32'd0);
      check("pause_sel", 32'(digit_sel), 32'd0);
      check("pause_idx", 32'(digit_idx), 32'd1);
    end
    enable = 1'b1;
    @(negedge clk);
    check("resume_seg", 32'(seg), 32'h4F);
    for (int j = 2; j < RD; j++) begin
      @(negedge clk);
      check("resume_idx", 32'(digit_idx), (j < RD - 1) ? 32'd1 : 32'd2);
    end

    // asynchronous reset between edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_seg", 32'(seg), 32'd0);
    check("arst_sel", 32'(digit_sel), 32'd0);
    check("arst_idx", 32'(digit_idx), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_seg", 32'(seg), 32'h3F);
    check("restart_idx", 32'(digit_idx), 32'd0);
`ifndef SEG_BRIGHTNESS_EN
    check("restart_sel", 32'(digit_sel), 32'd1);
`endif
    check_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
